// File: rtl/ram_sync_bytemem_if.sv
// ---------------------------------------------------------------------------
// ram_sync_bytemem_if
// Request/response bundle between the memory-stage control (master) and the
// byte-addressable data RAM (slave).
//   enable      request, held high until done is seen (four-phase)
//   readWrite   1 = write, 0 = read
//   dataType    00 byte, 01 halfword, 10 word, 11 reserved
//   signedLoad  1 = sign-extend byte/halfword reads
//   address     byte address of the access
//   dataIn      right-justified write data
//   dataOut     read data, held between reads
//   done        access complete, high until enable falls
//   error       access rejected (meaningful only while done = 1)
//   busy        high from request capture until the RAM is idle again
// ---------------------------------------------------------------------------
interface ram_sync_bytemem_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                  enable;
   logic                  readWrite;
   logic [1:0]            dataType;
   logic                  signedLoad;
   logic [ADDR_WIDTH-1:0] address;
   logic [31:0]           dataIn;
   logic [31:0]           dataOut;
   logic                  done;
   logic                  error;
   logic                  busy;

   modport master (
      output enable, readWrite, dataType, signedLoad, address, dataIn,
      input  dataOut, done, error, busy
   );

   modport slave (
      input  enable, readWrite, dataType, signedLoad, address, dataIn,
      output dataOut, done, error, busy
   );
endinterface

// File: rtl/ram_sync_bytemem.sv
// ---------------------------------------------------------------------------
// ram_sync_bytemem
// Clocked big-endian byte-addressable data RAM (2**ADDR_WIDTH bytes) with a
// latched four-phase enable/done handshake, WAIT_STATES extra cycles before
// each access, signed/unsigned sub-word loads and error reporting for
// misaligned or reserved-type accesses.
//   clk    system clock, rising edge
//   reset  asynchronous, active-high; clears control and dataOut, not memory
//   bus    ram_sync_bytemem_if slave modport (request/response signals)
// ---------------------------------------------------------------------------
module ram_sync_bytemem #(
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic                clk,
   input  logic                reset,
   ram_sync_bytemem_if.slave   bus
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] OFS1 = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] OFS2 = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] OFS3 = ADDR_WIDTH'(3);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

   state_t                state_q, state_n;
   logic [3:0]            cnt_q;

   // Latched request; data-only, so no reset
   logic                  rw_q;
   logic [1:0]            dtype_q;
   logic                  sl_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           din_q;

   logic [7:0]            mem [0:DEPTH-1];
   logic [31:0]           dout_q;
   logic                  req_bad;
   logic                  capture;
   logic                  commit;
   logic [7:0]            rd_byte;
   logic [15:0]           rd_half;
   logic [31:0]           rd_word;

   // Reserved type or misaligned halfword/word
   function automatic logic access_bad(input logic [1:0] dt, input logic [1:0] lo);
      case (dt)
         2'b00:   return 1'b0;
         2'b01:   return lo[0];
         2'b10:   return (lo != 2'b00);
         default: return 1'b1;
      endcase
   endfunction

   // Right-justify the loaded sub-word and fill the upper bits
   function automatic logic [31:0] load_ext(input logic [1:0] dt, input logic sgn,
                                            input logic [7:0] b, input logic [15:0] h,
                                            input logic [31:0] w);
      logic signed [7:0]  sb;
      logic signed [15:0] sh;
      logic signed [31:0] ext;
      sb  = b;
      sh  = h;
      ext = '0;
      case (dt)
         2'b00: begin
            if (sgn) ext = sb;
            else     ext = {24'b0, b};
         end
         2'b01: begin
            if (sgn) ext = sh;
            else     ext = {16'b0, h};
         end
         default: ext = w;
      endcase
      return ext;
   endfunction

   assign capture = (state_q == S_IDLE) && bus.enable;
   assign req_bad = access_bad(dtype_q, addr_q[1:0]);
   assign commit  = (state_q == S_ACCESS) && !req_bad;

   // ---- state register ----------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_n;
         if (capture)
            cnt_q <= 4'(WAIT_STATES);
         else if (state_q == S_WAIT)
            cnt_q <= cnt_q - 4'd1;
      end
   end

   // ---- next state ----------------------------------------------------------
   always_comb begin
      state_n = state_q;
      case (state_q)
         S_IDLE:   if (bus.enable) state_n = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
         S_WAIT:   if (cnt_q == 4'd1) state_n = S_ACCESS;
         S_ACCESS: state_n = S_DONE;
         S_DONE:   if (!bus.enable) state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

   // ---- outputs -------------------------------------------------------------
   always_comb begin
      bus.busy    = (state_q != S_IDLE);
      bus.done    = (state_q == S_DONE);
      bus.error   = (state_q == S_DONE) && req_bad;
      bus.dataOut = dout_q;
   end

   // ---- request latch -------------------------------------------------------
   always_ff @(posedge clk) begin
      if (capture) begin
         rw_q    <= bus.readWrite;
         dtype_q <= bus.dataType;
         sl_q    <= bus.signedLoad;
         addr_q  <= bus.address;
         din_q   <= bus.dataIn;
      end
   end

   // ---- memory access -------------------------------------------------------
   // Accepted halfword/word addresses are aligned, so OR-ing the low offset
   // bits equals adding them and can never wrap past the top of memory.
   always_ff @(posedge clk) begin
      if (commit && rw_q) begin
         case (dtype_q)
            2'b00: mem[addr_q] <= din_q[7:0];
            2'b01: begin
               mem[addr_q]        <= din_q[15:8];
               mem[addr_q | OFS1] <= din_q[7:0];
            end
            default: begin
               mem[addr_q]        <= din_q[31:24];
               mem[addr_q | OFS1] <= din_q[23:16];
               mem[addr_q | OFS2] <= din_q[15:8];
               mem[addr_q | OFS3] <= din_q[7:0];
            end
         endcase
      end
   end

   always_comb begin
      rd_byte = mem[addr_q];
      rd_half = {mem[addr_q], mem[addr_q | OFS1]};
      rd_word = {mem[addr_q], mem[addr_q | OFS1], mem[addr_q | OFS2], mem[addr_q | OFS3]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         dout_q <= 32'd0;
      else if (commit && !rw_q)
         dout_q <= load_ext(dtype_q, sl_q, rd_byte, rd_half, rd_word);
   end

endmodule

// File: tb/tb_ram_sync_bytemem.sv
// ---------------------------------------------------------------------------
// tb_ram_sync_bytemem
// Directed bench for ram_sync_bytemem: three instances (WAIT_STATES 0, 1, 3)
// share the clock, reset and request fields; each has its own enable.
// Slot 0 = WAIT_STATES 0, slot 1 = WAIT_STATES 1, slot 2 = WAIT_STATES 3.
// ---------------------------------------------------------------------------
module tb_ram_sync_bytemem;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en [3];
   logic        rw;
   logic [1:0]  dt;
   logic        sl;
   logic [7:0]  addr;
   logic [31:0] din;

   logic        dn [3];
   logic        er [3];
   logic        by [3];
   logic [31:0] dq [3];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ram_sync_bytemem_if #(.ADDR_WIDTH(8)) bus0 ();
   ram_sync_bytemem_if #(.ADDR_WIDTH(8)) bus1 ();
   ram_sync_bytemem_if #(.ADDR_WIDTH(8)) bus3 ();

   ram_sync_bytemem #(.ADDR_WIDTH(8), .WAIT_STATES(0)) u_ws0 (.clk(clk), .reset(reset), .bus(bus0));
   ram_sync_bytemem #(.ADDR_WIDTH(8), .WAIT_STATES(1)) u_ws1 (.clk(clk), .reset(reset), .bus(bus1));
   ram_sync_bytemem #(.ADDR_WIDTH(8), .WAIT_STATES(3)) u_ws3 (.clk(clk), .reset(reset), .bus(bus3));

   assign bus0.enable = en[0];
   assign bus1.enable = en[1];
   assign bus3.enable = en[2];
   assign bus0.readWrite = rw;   assign bus1.readWrite = rw;   assign bus3.readWrite = rw;
   assign bus0.dataType = dt;    assign bus1.dataType = dt;    assign bus3.dataType = dt;
   assign bus0.signedLoad = sl;  assign bus1.signedLoad = sl;  assign bus3.signedLoad = sl;
   assign bus0.address = addr;   assign bus1.address = addr;   assign bus3.address = addr;
   assign bus0.dataIn = din;     assign bus1.dataIn = din;     assign bus3.dataIn = din;

   assign dn[0] = bus0.done;    assign dn[1] = bus1.done;    assign dn[2] = bus3.done;
   assign er[0] = bus0.error;   assign er[1] = bus1.error;   assign er[2] = bus3.error;
   assign by[0] = bus0.busy;    assign by[1] = bus1.busy;    assign by[2] = bus3.busy;
   assign dq[0] = bus0.dataOut; assign dq[1] = bus1.dataOut; assign dq[2] = bus3.dataOut;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // One full four-phase transaction on slot w. lat counts rising edges from
   // the capturing edge to the edge where done is first seen high.
   task automatic access(input int w, input logic wr, input logic [1:0] t, input logic s,
                         input logic [7:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] q, output logic e);
      @(negedge clk);
      rw = wr; dt = t; sl = s; addr = a; din = d;
      en[w] = 1'b1;
      @(posedge clk);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!dn[w] && lat < 40);
      q = dq[w];
      e = er[w];
      en[w] = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic xfer(input string tag, input int w, input logic wr, input logic [1:0] t,
                       input logic s, input logic [7:0] a, input logic [31:0] d,
                       input int xlat, input logic xerr, output logic [31:0] q);
      int   lat;
      logic e;
      access(w, wr, t, s, a, d, lat, q, e);
      check({tag, "_lat"}, 32'(lat), 32'(xlat));
      check({tag, "_err"}, {31'b0, e}, {31'b0, xerr});
      check({tag, "_idle"}, {30'b0, by[w], dn[w]}, 32'd0);
   endtask

   initial begin
      logic [31:0] q;
      int          first;
      int          hi;

      for (int i = 0; i < 3; i++) en[i] = 1'b0;
      rw = 1'b0; dt = 2'b00; sl = 1'b0; addr = 8'h00; din = 32'h0;

      // reset state
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_dout", dq[1], 32'h0);
      check("rst_flags", {29'b0, dn[1], er[1], by[1]}, 32'h0);
      reset = 1'b0;

      // WAIT_STATES = 1: byte writes then halfword read
      xfer("wb00", 1, 1'b1, 2'b00, 1'b0, 8'h00, 32'h0000_000F, 2, 1'b0, q);
      xfer("wb01", 1, 1'b1, 2'b00, 1'b0, 8'h01, 32'h0000_00F0, 2, 1'b0, q);
      xfer("rh00", 1, 1'b0, 2'b01, 1'b0, 8'h00, 32'h0, 2, 1'b0, q);
      check("rh00_data", q, 32'h0000_0FF0);

      // word write, sub-word reads
      xfer("ww04", 1, 1'b1, 2'b10, 1'b0, 8'h04, 32'h0F02_090A, 2, 1'b0, q);
      xfer("rb05", 1, 1'b0, 2'b00, 1'b0, 8'h05, 32'h0, 2, 1'b0, q);
      check("rb05_data", q, 32'h0000_0002);
      xfer("rh06", 1, 1'b0, 2'b01, 1'b0, 8'h06, 32'h0, 2, 1'b0, q);
      check("rh06_data", q, 32'h0000_090A);
      xfer("rw04", 1, 1'b0, 2'b10, 1'b0, 8'h04, 32'h0, 2, 1'b0, q);
      check("rw04_data", q, 32'h0F02_090A);

      // sign extension
      xfer("ww0c", 1, 1'b1, 2'b10, 1'b0, 8'h0C, 32'h80A0_B0C0, 2, 1'b0, q);
      xfer("rh0c_s", 1, 1'b0, 2'b01, 1'b1, 8'h0C, 32'h0, 2, 1'b0, q);
      check("rh0c_s_data", q, 32'hFFFF_80A0);
      xfer("rh0e_u", 1, 1'b0, 2'b01, 1'b0, 8'h0E, 32'h0, 2, 1'b0, q);
      check("rh0e_u_data", q, 32'h0000_B0C0);
      xfer("rw0c_s", 1, 1'b0, 2'b10, 1'b1, 8'h0C, 32'h0, 2, 1'b0, q);
      check("rw0c_s_data", q, 32'h80A0_B0C0);
      xfer("wb10", 1, 1'b1, 2'b00, 1'b0, 8'h10, 32'h0000_0080, 2, 1'b0, q);
      xfer("rb10_s", 1, 1'b0, 2'b00, 1'b1, 8'h10, 32'h0, 2, 1'b0, q);
      check("rb10_s_data", q, 32'hFFFF_FF80);
      xfer("rb10_u", 1, 1'b0, 2'b00, 1'b0, 8'h10, 32'h0, 2, 1'b0, q);
      check("rb10_u_data", q, 32'h0000_0080);

      // error cases: dataOut keeps the prior read value, memory untouched
      xfer("e_rh01", 1, 1'b0, 2'b01, 1'b0, 8'h01, 32'h0, 2, 1'b1, q);
      check("e_rh01_dout", q, 32'h0000_0080);
      xfer("e_rh00_chk", 1, 1'b0, 2'b01, 1'b0, 8'h00, 32'h0, 2, 1'b0, q);
      check("e_rh00_chk_data", q, 32'h0000_0FF0);
      xfer("e_ww06", 1, 1'b1, 2'b10, 1'b0, 8'h06, 32'hAABB_CCDD, 2, 1'b1, q);
      check("e_ww06_dout", q, 32'h0000_0FF0);
      xfer("e_rw04_chk", 1, 1'b0, 2'b10, 1'b0, 8'h04, 32'h0, 2, 1'b0, q);
      check("e_rw04_chk_data", q, 32'h0F02_090A);
      xfer("e_t11", 1, 1'b1, 2'b11, 1'b0, 8'h10, 32'h0000_0055, 2, 1'b1, q);
      check("e_t11_dout", q, 32'h0F02_090A);
      xfer("e_rb10_chk", 1, 1'b0, 2'b00, 1'b0, 8'h10, 32'h0, 2, 1'b0, q);
      check("e_rb10_chk_data", q, 32'h0000_0080);

      // reset during WAIT aborts a pending word write
      xfer("ww08", 1, 1'b1, 2'b10, 1'b0, 8'h08, 32'h1122_3344, 2, 1'b0, q);
      xfer("rw08", 1, 1'b0, 2'b10, 1'b0, 8'h08, 32'h0, 2, 1'b0, q);
      check("rw08_data", q, 32'h1122_3344);
      @(negedge clk);
      rw = 1'b1; dt = 2'b10; sl = 1'b0; addr = 8'h08; din = 32'hDEAD_BEEF;
      en[1] = 1'b1;
      @(posedge clk);
      #2;
      check("abort_busy", {31'b0, by[1]}, 32'd1);
      reset = 1'b1;
      #1;
      check("abort_dout", dq[1], 32'h0);
      check("abort_flags", {29'b0, dn[1], er[1], by[1]}, 32'h0);
      @(negedge clk);
      en[1] = 1'b0;
      reset = 1'b0;
      xfer("abort_rd", 1, 1'b0, 2'b10, 1'b0, 8'h08, 32'h0, 2, 1'b0, q);
      check("abort_rd_data", q, 32'h1122_3344);

      // WAIT_STATES = 0
      xfer("ws0_wb", 0, 1'b1, 2'b00, 1'b0, 8'h03, 32'h0000_005A, 1, 1'b0, q);
      xfer("ws0_rb", 0, 1'b0, 2'b00, 1'b1, 8'h03, 32'h0, 1, 1'b0, q);
      check("ws0_rb_data", q, 32'h0000_005A);

      // WAIT_STATES = 3
      xfer("ws3_ww", 2, 1'b1, 2'b10, 1'b0, 8'h20, 32'h0102_0304, 4, 1'b0, q);
      xfer("ws3_rh", 2, 1'b0, 2'b01, 1'b0, 8'h22, 32'h0, 4, 1'b0, q);
      check("ws3_rh_data", q, 32'h0000_0304);

      // enable dropped during WAIT: access completes, done pulses once
      @(negedge clk);
      rw = 1'b1; dt = 2'b00; sl = 1'b0; addr = 8'h24; din = 32'h0000_003C;
      en[2] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en[2] = 1'b0;
      first = 0;
      hi    = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (dn[2]) begin
            hi++;
            if (first == 0) first = i;
         end
      end
      check("pulse_edge", 32'(first), 32'd4);
      check("pulse_width", 32'(hi), 32'd1);
      xfer("pulse_rd", 2, 1'b0, 2'b00, 1'b0, 8'h24, 32'h0, 4, 1'b0, q);
      check("pulse_rd_data", q, 32'h0000_003C);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
